mem_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream memory port among N requester handles. Each requester issues single-word reads or writes with region bounds. The arbiter bounds-checks the pointer, serializes accepted accesses onto the memory port, and returns a one-cycle completion pulse with load data. It sits between the compute/SPI clients and the single SRAM/SPI memory controller.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_arbiter_rr.sv | 37 +++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter slice.
// Contents:
//   ADDR_SIZE, DATA_SIZE, CACHE_SIZE : default widths and sizes of the memory subsystem
//   arb_state_t                      : arbiter FSM states
//   mem_req_t                        : one requester's access, packed
package mem_pkg;

    localparam int ADDR_SIZE  = 23;
    localparam int DATA_SIZE  = 32;
    localparam int CACHE_SIZE = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] ptr;
        logic [ADDR_SIZE-1:0] region_begin;
        logic [ADDR_SIZE-1:0] region_end;
        logic [DATA_SIZE-1:0] data;
        logic                 r_en;
        logic                 w_en;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin priority rotation.
// Ports:
//   pending     [N]   : requesters that want service
//   last_grant  [IW]  : most recently granted index; search starts one past it
//   grant_valid       : at least one requester pending
//   grant_idx   [IW]  : first pending index at or after last_grant+1 (mod N)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] last_grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    // Walk offsets from farthest to nearest so the nearest pending
    // requester is the last assignment and therefore wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            int             s;
            logic [IW-1:0]  idx;
            s = int'(last_grant) + k;
            if (s >= N) begin
                s = s - N;
            end
            idx = IW'(s);
            if (pending[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among N requesters.
// Each requester issues a single-word read or write with region bounds;
// out-of-region or malformed (both/neither enable) accesses are rejected
// without touching the memory port.
// Ports:
//   clock, reset                    : clock, asynchronous active-high reset
//   req_r_en/req_w_en [N]           : per-requester level requests
//   req_ptr/region_begin/region_end : packed N x ADDR_SIZE, slice i = requester i
//   req_data_store                  : packed N x DATA_SIZE write data
//   req_avail [N]                   : all ones while idle
//   req_done/req_err [N]            : one-cycle completion / rejection on the granted bit
//   req_data_load                   : read data, valid with req_done
//   mem_*                           : downstream memory port, enables held until mem_done
//   dbg_state                       : current FSM state
//
// Handshake: a request is a level on r_en/w_en, sampled only in IDLE. The
// granted requester sees req_done for exactly one cycle and must drop its
// enable on the following edge; an enable still high in IDLE is a new request.
// Downstream, mem_r_en/mem_w_en stay high with stable address/data until the
// cycle in which mem_done is seen; mem_done in any other state is ignored.
module mem_arbiter #(
    parameter int N         = 4,
    parameter int ADDR_SIZE = 23,
    parameter int DATA_SIZE = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           req_r_en,
    input  logic [N-1:0]           req_w_en,
    input  logic [N*ADDR_SIZE-1:0] req_ptr,
    input  logic [N*ADDR_SIZE-1:0] req_region_begin,
    input  logic [N*ADDR_SIZE-1:0] req_region_end,
    input  logic [N*DATA_SIZE-1:0] req_data_store,
    output logic [N-1:0]           req_avail,
    output logic [N-1:0]           req_done,
    output logic [N-1:0]           req_err,
    output logic [DATA_SIZE-1:0]   req_data_load,
    output logic                   mem_r_en,
    output logic                   mem_w_en,
    output logic [ADDR_SIZE-1:0]   mem_addr,
    output logic [DATA_SIZE-1:0]   mem_data_store,
    input  logic                   mem_done,
    input  logic [DATA_SIZE-1:0]   mem_data_load,
    output mem_pkg::arb_state_t    dbg_state
);

    import mem_pkg::*;

    localparam int           IW  = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    arb_state_t           r_state;
    logic [IW-1:0]        r_last_grant;
    logic [IW-1:0]        r_grant;
    logic                 r_is_write;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [DATA_SIZE-1:0] r_data_store;
    logic [DATA_SIZE-1:0] r_data_load;
    logic                 r_mem_r_en;
    logic                 r_mem_w_en;
    logic [N-1:0]         r_done;
    logic [N-1:0]         r_err;
    logic [N-1:0]         r_avail;

    logic [N-1:0]         w_pending;
    logic                 w_grant_valid;
    logic [IW-1:0]        w_grant_idx;
    logic [ADDR_SIZE-1:0] w_ptr   [N];
    logic [ADDR_SIZE-1:0] w_begin [N];
    logic [ADDR_SIZE-1:0] w_end   [N];
    logic [DATA_SIZE-1:0] w_store [N];
    logic                 w_sel_r;
    logic                 w_sel_w;
    logic                 w_sel_ok;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign w_ptr[i]   = req_ptr[i*ADDR_SIZE +: ADDR_SIZE];
        assign w_begin[i] = req_region_begin[i*ADDR_SIZE +: ADDR_SIZE];
        assign w_end[i]   = req_region_end[i*ADDR_SIZE +: ADDR_SIZE];
        assign w_store[i] = req_data_store[i*DATA_SIZE +: DATA_SIZE];
    end

    assign w_pending = req_r_en | req_w_en;

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .pending     (w_pending),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Bounds and op check on the selected requester (unsigned compare).
    assign w_sel_r  = req_r_en[w_grant_idx];
    assign w_sel_w  = req_w_en[w_grant_idx];
    assign w_sel_ok = (w_sel_r ^ w_sel_w)
                    && (w_ptr[w_grant_idx] >= w_begin[w_grant_idx])
                    && (w_ptr[w_grant_idx] <= w_end[w_grant_idx]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= IW'(N-1);
            r_grant      <= '0;
            r_is_write   <= 1'b0;
            r_addr       <= '0;
            r_data_store <= '0;
            r_data_load  <= '0;
            r_mem_r_en   <= 1'b0;
            r_mem_w_en   <= 1'b0;
            r_done       <= '0;
            r_err        <= '0;
            r_avail      <= '1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_grant      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_is_write   <= w_sel_w;
                        r_avail      <= '0;
                        if (w_sel_ok) begin
                            r_addr       <= w_ptr[w_grant_idx];
                            r_data_store <= w_store[w_grant_idx];
                            r_mem_r_en   <= w_sel_r;
                            r_mem_w_en   <= w_sel_w;
                            r_state      <= ISSUE;
                        end else begin
                            // Rejected: complete immediately, memory port untouched.
                            r_done      <= ONE << w_grant_idx;
                            r_err       <= ONE << w_grant_idx;
                            r_data_load <= '0;
                            r_state     <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_done) begin
                        r_mem_r_en  <= 1'b0;
                        r_mem_w_en  <= 1'b0;
                        r_done      <= ONE << r_grant;
                        r_err       <= '0;
                        r_data_load <= r_is_write ? '0 : mem_data_load;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    r_done      <= '0;
                    r_err       <= '0;
                    r_data_load <= '0;
                    r_avail     <= '1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_mem_r_en <= 1'b0;
                    r_mem_w_en <= 1'b0;
                    r_done     <= '0;
                    r_err      <= '0;
                    r_avail    <= '1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign req_avail      = r_avail;
    assign req_done       = r_done;
    assign req_err        = r_err;
    assign req_data_load  = r_data_load;
    assign mem_r_en       = r_mem_r_en;
    assign mem_w_en       = r_mem_w_en;
    assign mem_addr       = r_addr;
    assign mem_data_store = r_data_store;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int N  = 4;
    localparam int AW = 23;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    tb_r_en = '0;
    logic [N-1:0]    tb_w_en = '0;
    logic [N*AW-1:0] tb_ptr = '0;
    logic [N*AW-1:0] tb_beg = '0;
    logic [N*AW-1:0] tb_end = '0;
    logic [N*DW-1:0] tb_data = '0;
    logic [N-1:0]    req_avail, req_done, req_err;
    logic [DW-1:0]   req_data_load;
    logic            mem_r_en, mem_w_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data_store;
    logic            mem_done = 1'b0;
    logic [DW-1:0]   mem_data_load = '0;
    arb_state_t      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int m_last   = N - 1;   // reference model: last granted requester

    always #5 clock = ~clock;

    mem_arbiter #(.N(N), .ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_r_en         (tb_r_en),
        .req_w_en         (tb_w_en),
        .req_ptr          (tb_ptr),
        .req_region_begin (tb_beg),
        .req_region_end   (tb_end),
        .req_data_store   (tb_data),
        .req_avail        (req_avail),
        .req_done         (req_done),
        .req_err          (req_err),
        .req_data_load    (req_data_load),
        .mem_r_en         (mem_r_en),
        .mem_w_en         (mem_w_en),
        .mem_addr         (mem_addr),
        .mem_data_store   (mem_data_store),
        .mem_done         (mem_done),
        .mem_data_load    (mem_data_load),
        .dbg_state        (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit r, input bit w, input int p,
                           input int b, input int e, input logic [DW-1:0] d);
        tb_r_en[i]           = r;
        tb_w_en[i]           = w;
        tb_ptr[i*AW +: AW]   = AW'(p);
        tb_beg[i*AW +: AW]   = AW'(b);
        tb_end[i*AW +: AW]   = AW'(e);
        tb_data[i*DW +: DW]  = d;
    endtask

    // Next requester to be served: first pending one scanning upward from m_last+1.
    function automatic int model_winner();
        for (int k = 1; k <= N; k++) begin
            int c = (m_last + k) % N;
            if (tb_r_en[c] || tb_w_en[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit model_valid(input int c);
        int p = int'(tb_ptr[c*AW +: AW]);
        int b = int'(tb_beg[c*AW +: AW]);
        int e = int'(tb_end[c*AW +: AW]);
        return ((int'(tb_r_en[c]) + int'(tb_w_en[c])) == 1) && (b <= p) && (p <= e);
    endfunction

    // One full transaction from IDLE (at a negedge) back to IDLE (at a negedge).
    task automatic do_txn(input int delay, input logic [DW-1:0] rd, input bit drop, output int w);
        bit            ok, is_wr;
        logic [N-1:0]  oh;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_store;
        w         = model_winner();
        ok        = model_valid(w);
        is_wr     = tb_w_en[w];
        oh        = N'(1 << w);
        exp_addr  = tb_ptr[w*AW +: AW];
        exp_store = tb_data[w*DW +: DW];
        @(posedge clock); @(negedge clock);
        m_last = w;
        if (ok) begin
            chk("issue_r_en", 64'(mem_r_en), 64'(!is_wr));
            chk("issue_w_en", 64'(mem_w_en), 64'(is_wr));
            chk("issue_addr", 64'(mem_addr), 64'(exp_addr));
            if (is_wr) chk("issue_store", 64'(mem_data_store), 64'(exp_store));
            chk("issue_avail", 64'(req_avail), 64'(0));
            chk("issue_done", 64'(req_done), 64'(0));
            for (int j = 0; j < delay; j++) begin
                @(posedge clock); @(negedge clock);
                chk("hold_en", 64'({mem_r_en, mem_w_en}), 64'({!is_wr, is_wr}));
                chk("hold_addr", 64'(mem_addr), 64'(exp_addr));
            end
            mem_done = 1'b1; mem_data_load = rd;
            @(posedge clock); @(negedge clock);
            mem_done = 1'b0; mem_data_load = $urandom;
            chk("resp_done", 64'(req_done), 64'(oh));
            chk("resp_err", 64'(req_err), 64'(0));
            chk("resp_load", 64'(req_data_load), is_wr ? 64'(0) : 64'(rd));
            chk("resp_mem_en", 64'({mem_r_en, mem_w_en}), 64'(0));
        end else begin
            chk("rej_done", 64'(req_done), 64'(oh));
            chk("rej_err", 64'(req_err), 64'(oh));
            chk("rej_load", 64'(req_data_load), 64'(0));
            chk("rej_mem_en", 64'({mem_r_en, mem_w_en}), 64'(0));
        end
        if (drop) begin
            tb_r_en[w] = 1'b0;
            tb_w_en[w] = 1'b0;
        end
        @(posedge clock); @(negedge clock);
        chk("back_avail", 64'(req_avail), 64'({N{1'b1}}));
        chk("back_done", 64'({req_done, req_err}), 64'(0));
    endtask

    initial begin
        int w;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        // Reset state
        @(negedge clock); @(negedge clock);
        chk("rst_avail", 64'(req_avail), 64'({N{1'b1}}));
        chk("rst_done_err", 64'({req_done, req_err}), 64'(0));
        chk("rst_load", 64'(req_data_load), 64'(0));
        chk("rst_mem_en", 64'({mem_r_en, mem_w_en}), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_store", 64'(mem_data_store), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        reset = 1'b0;
        @(negedge clock);

        // Single read
        set_req(0, 1, 0, 'h10, 'h0, 'hFF, '0);
        do_txn(2, 32'hDEADBEEF, 1, w);
        chk("read_winner", 64'(w), 64'(0));

        // Out-of-range write
        set_req(1, 0, 1, 'h200, 'h0, 'h1FF, 32'h12345678);
        do_txn(0, '0, 1, w);
        chk("oor_winner", 64'(w), 64'(1));

        // Both enables set
        set_req(2, 1, 1, 'h20, 'h0, 'hFF, 32'h1);
        do_txn(0, '0, 1, w);

        // Valid write
        set_req(3, 0, 1, 'h44, 'h40, 'h80, 32'hCAFEF00D);
        do_txn(1, 32'h55555555, 1, w);

        // mem_done in IDLE is ignored
        mem_done = 1'b1; mem_data_load = 32'hFFFFFFFF;
        @(posedge clock); @(negedge clock);
        mem_done = 1'b0;
        chk("stray_done", 64'({req_done, req_err}), 64'(0));
        chk("stray_avail", 64'(req_avail), 64'({N{1'b1}}));

        // Contention: all hold their requests; m_last is 3 so service starts at 0
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 'h100 + i, 'h0, 'h1FF, '0);
        for (int t = 0; t < 5; t++) begin
            do_txn(t % 2, $urandom, 0, w);
            chk("rr_order", 64'(w), 64'(exp_order[t]));
        end
        tb_r_en = '0; tb_w_en = '0;

        // Boundaries
        set_req(1, 1, 0, 'h30, 'h30, 'h50, '0);
        do_txn(0, $urandom, 1, w);
        set_req(1, 0, 1, 'h50, 'h30, 'h50, 32'hA5A5A5A5);
        do_txn(0, $urandom, 1, w);
        set_req(1, 1, 0, 'h51, 'h30, 'h50, '0);
        do_txn(0, $urandom, 1, w);

        // Randomized batches
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++) begin
                int op = $urandom_range(0, 3);
                set_req(i, op[0], op[1], $urandom_range(0, 255), $urandom_range(0, 100),
                        $urandom_range(50, 200), $urandom);
            end
            while (model_winner() >= 0) begin
                do_txn($urandom_range(0, 3), $urandom, 1, w);
            end
        end

        // Reset while an access is in flight
        set_req(1, 1, 0, 'h10, 'h0, 'hFF, '0);
        @(posedge clock); @(negedge clock);
        chk("pre_rst_r_en", 64'(mem_r_en), 64'(1));
        #1 reset = 1'b1;
        #1;
        chk("async_rst_r_en", 64'(mem_r_en), 64'(0));
        chk("async_rst_done", 64'(req_done), 64'(0));
        chk("async_rst_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        m_last = N - 1;
        set_req(0, 1, 0, 'h08, 'h0, 'hFF, '0);
        do_txn(0, $urandom, 1, w);
        chk("post_rst_first", 64'(w), 64'(0));
        do_txn(1, $urandom, 1, w);
        chk("post_rst_second", 64'(w), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
